eth_tx_sched: RTL and testbench

//  Transmit scheduler between the PDM sample buffer and the 10BASE-T eth_tx serializer.

---
 rtl/eth_tx_sched_if.sv | 35 +++
 rtl/eth_tx_sched.sv | 203 ++++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if
//   Bundles the scheduler's buffer/serializer-facing signals.
//   master : scheduler side (drives tx_start, nlp_pulse, tx_sel, frame_cnt, tx_err)
//   slave  : environment side (drives enable, buf_level, tx_busy)
//   Ports carried:
//     enable     allow new frames (does not gate link pulses)
//     buf_level  sample buffer fill level in bytes, LEVEL_W bits
//     tx_busy    eth_tx frame in progress
//     tx_start   frame start strobe, one bit-tick wide
//     nlp_pulse  normal link pulse to the line driver mux
//     tx_sel     1 = frame path owns the line, 0 = NLP/idle path
//     frame_cnt  frames started, 16-bit wrapping
//     tx_err     sticky SEND watchdog error
interface eth_tx_sched_if #(
  parameter int LEVEL_W = 12
);
  logic               enable;
  logic [LEVEL_W-1:0] buf_level;
  logic               tx_busy;
  logic               tx_start;
  logic               nlp_pulse;
  logic               tx_sel;
  logic [15:0]        frame_cnt;
  logic               tx_err;

  modport master (
    input  enable, buf_level, tx_busy,
    output tx_start, nlp_pulse, tx_sel, frame_cnt, tx_err
  );

  modport slave (
    output enable, buf_level, tx_busy,
    input  tx_start, nlp_pulse, tx_sel, frame_cnt, tx_err
  );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched
//   Transmit scheduler between the PDM sample buffer and the 10BASE-T eth_tx
//   serializer. Starts a frame once the buffer holds a full payload, enforces
//   the inter-frame gap and emits Normal Link Pulses while the line is idle.
//   Link pulses take priority over frames. Every state/counter/output update
//   is qualified by the bit-tick enable eth_clk_en.
//   Ports:
//     clk        system clock
//     rst_n      asynchronous reset, active low
//     eth_clk_en bit-tick enable, one clk cycle wide
//     bus        eth_tx_sched_if.master (enable, buf_level, tx_busy in;
//                tx_start, nlp_pulse, tx_sel, frame_cnt, tx_err out)
//   Build option:
//     SCHED_TIMEOUT_EN  adds a SEND watchdog that sets sticky tx_err after
//                       TX_TIMEOUT ticks without a busy high->low sequence.
//                       Undefined: SEND waits indefinitely, tx_err tied low.
module eth_tx_sched #(
  parameter int LEVEL_W     = 12,
  parameter int FILL_THRESH = 1024,
  parameter int IFG_TICKS   = 96,
  parameter int NLP_PERIOD  = 160000,
  parameter int NLP_LEN     = 1,
  parameter int TX_TIMEOUT  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eth_clk_en,
  eth_tx_sched_if.master    bus
);

  localparam int NLP_TMR_W = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;
  localparam int NLP_CNT_W = (NLP_LEN    > 1) ? $clog2(NLP_LEN)    : 1;
  localparam int IFG_CNT_W = (IFG_TICKS  > 1) ? $clog2(IFG_TICKS)  : 1;

  localparam logic [LEVEL_W-1:0]   FILL_L    = LEVEL_W'(FILL_THRESH);
  localparam logic [NLP_TMR_W-1:0] NLP_RELOAD = NLP_TMR_W'(NLP_PERIOD - 1);
  localparam logic [NLP_CNT_W-1:0] NLP_LEN_M1 = NLP_CNT_W'(NLP_LEN - 1);
  localparam logic [IFG_CNT_W-1:0] IFG_M1     = IFG_CNT_W'(IFG_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_IFG,
    S_NLP
  } state_t;

  state_t               state_q,     state_d;
  logic [NLP_TMR_W-1:0] nlp_tmr_q,   nlp_tmr_d;
  logic [NLP_CNT_W-1:0] nlp_cnt_q,   nlp_cnt_d;
  logic [IFG_CNT_W-1:0] ifg_cnt_q,   ifg_cnt_d;
  logic                 busy_seen_q, busy_seen_d;
  logic                 tx_start_q,  tx_start_d;
  logic                 nlp_pulse_q, nlp_pulse_d;
  logic                 tx_sel_q,    tx_sel_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            tx_err_q, tx_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    nlp_tmr_d   = nlp_tmr_q;
    nlp_cnt_d   = nlp_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    busy_seen_d = busy_seen_q;
    tx_start_d  = tx_start_q;
    nlp_pulse_d = nlp_pulse_q;
    tx_sel_d    = tx_sel_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SCHED_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    tx_err_d    = tx_err_q;
`endif

    if (eth_clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          // Link pulse is checked first so it wins over a frame start on the same tick.
          if (nlp_tmr_q == '0) begin
            state_d     = S_NLP;
            nlp_pulse_d = 1'b1;
            nlp_cnt_d   = NLP_LEN_M1;
          end else begin
            nlp_tmr_d = nlp_tmr_q - 1'b1;
            if (bus.enable && (bus.buf_level >= FILL_L)) begin
              state_d     = S_START;
              tx_start_d  = 1'b1;
              tx_sel_d    = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end

        S_START: begin
          state_d     = S_SEND;
          tx_start_d  = 1'b0;
          busy_seen_d = 1'b0;
`ifdef SCHED_TIMEOUT_EN
          wd_cnt_d    = '0;
`endif
        end

        S_SEND: begin
          if (bus.tx_busy) begin
            busy_seen_d = 1'b1;
          end
          // Completion needs busy to have been seen high on an earlier tick,
          // so a late-rising tx_busy is not mistaken for an already-finished frame.
          if (!bus.tx_busy && busy_seen_q) begin
            state_d   = S_IFG;
            tx_sel_d  = 1'b0;
            ifg_cnt_d = IFG_M1;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wd_cnt_q == WD_LAST) begin
            state_d   = S_IFG;
            tx_sel_d  = 1'b0;
            ifg_cnt_d = IFG_M1;
            tx_err_d  = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`endif
        end

        S_IFG: begin
          if (ifg_cnt_q == '0) begin
            state_d   = S_IDLE;
            nlp_tmr_d = NLP_RELOAD;
          end else begin
            ifg_cnt_d = ifg_cnt_q - 1'b1;
          end
        end

        S_NLP: begin
          if (nlp_cnt_q == '0) begin
            state_d     = S_IDLE;
            nlp_pulse_d = 1'b0;
            nlp_tmr_d   = NLP_RELOAD;
          end else begin
            nlp_cnt_d = nlp_cnt_q - 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nlp_tmr_q   <= NLP_RELOAD;
      nlp_cnt_q   <= '0;
      ifg_cnt_q   <= '0;
      busy_seen_q <= 1'b0;
      tx_start_q  <= 1'b0;
      nlp_pulse_q <= 1'b0;
      tx_sel_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      nlp_tmr_q   <= nlp_tmr_d;
      nlp_cnt_q   <= nlp_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      busy_seen_q <= busy_seen_d;
      tx_start_q  <= tx_start_d;
      nlp_pulse_q <= nlp_pulse_d;
      tx_sel_q    <= tx_sel_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      tx_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      tx_err_q <= tx_err_d;
    end
  end

  assign bus.tx_err = tx_err_q;
`else
  assign bus.tx_err = 1'b0;
`endif

  assign bus.tx_start  = tx_start_q;
  assign bus.nlp_pulse = nlp_pulse_q;
  assign bus.tx_sel    = tx_sel_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched
//   Directed testbench for eth_tx_sched with FILL_THRESH=4, IFG_TICKS=8,
//   NLP_PERIOD=200, NLP_LEN=2, TX_TIMEOUT=64 and eth_clk_en every 2nd clk.
//   Tick numbers below count eth_clk_en-qualified edges after reset release.
module tb_eth_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic eth_clk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  eth_tx_sched_if #(.LEVEL_W(12)) bus ();

  eth_tx_sched #(
    .LEVEL_W     (12),
    .FILL_THRESH (4),
    .IFG_TICKS   (8),
    .NLP_PERIOD  (200),
    .NLP_LEN     (2),
    .TX_TIMEOUT  (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eth_clk_en (eth_clk_en),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Enable toggles on the falling edge, so it is high on every second rising edge.
  always @(negedge clk) eth_clk_en = ~eth_clk_en;

  task automatic tick();
    @(posedge clk);
    while (!eth_clk_en) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.buf_level = '0;
    bus.tx_busy = 1'b0;
    repeat (4) @(posedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.buf_level = '0;
    bus.tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.tx_start, bus.nlp_pulse, bus.tx_sel, bus.tx_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.tx_start, bus.nlp_pulse, bus.tx_sel, bus.tx_err});
    end
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", bus.frame_cnt);
    end
    tick();
    rst_n = 1'b1;
    ticks(5);
    checks++;
    if ({bus.tx_start, bus.nlp_pulse, bus.tx_sel} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_quiet: got %b expected 000",
               {bus.tx_start, bus.nlp_pulse, bus.tx_sel});
    end
  endtask

  // Scenario 1: idle line, link pulses only.
  task automatic test_nlp_idle();
    int starts;
    starts = 0;
    do_reset();
    for (int t = 1; t <= 199; t++) begin
      tick();
      if (bus.tx_start) starts++;
    end
    checks++;
    if (bus.nlp_pulse !== 1'b0) begin
      errors++;
      $display("FAIL nlp_t199: got %b expected 0", bus.nlp_pulse);
    end
    tick();
    checks++;
    if (bus.nlp_pulse !== 1'b1) begin
      errors++;
      $display("FAIL nlp_t200_rise: got %b expected 1", bus.nlp_pulse);
    end
    tick();
    checks++;
    if (bus.nlp_pulse !== 1'b1) begin
      errors++;
      $display("FAIL nlp_t201_hold: got %b expected 1", bus.nlp_pulse);
    end
    tick();
    checks++;
    if (bus.nlp_pulse !== 1'b0) begin
      errors++;
      $display("FAIL nlp_t202_fall: got %b expected 0", bus.nlp_pulse);
    end
    for (int t = 203; t <= 401; t++) begin
      tick();
      if (bus.tx_start) starts++;
    end
    checks++;
    if (bus.nlp_pulse !== 1'b0) begin
      errors++;
      $display("FAIL nlp_t401: got %b expected 0", bus.nlp_pulse);
    end
    tick();
    checks++;
    if (bus.nlp_pulse !== 1'b1) begin
      errors++;
      $display("FAIL nlp_t402_second_rise: got %b expected 1", bus.nlp_pulse);
    end
    checks++;
    if (starts !== 0) begin
      errors++;
      $display("FAIL nlp_idle_no_start: got %0d starts expected 0", starts);
    end
  endtask

  // Scenario 2: frame with a 50-tick busy, then a back-to-back second frame.
  task automatic test_frame();
    int early;
    early = 0;
    do_reset();
    bus.enable = 1'b1;
    bus.buf_level = 12'd4;
    tick();  // t1: start
    checks++;
    if ({bus.tx_start, bus.tx_sel} !== 2'b11) begin
      errors++;
      $display("FAIL frame_start: got %b expected 11", {bus.tx_start, bus.tx_sel});
    end
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frame_cnt_1: got %0d expected 1", bus.frame_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.tx_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_2clk: got %b expected 1", bus.tx_start);
    end
    tick();  // t2: into SEND
    checks++;
    if ({bus.tx_start, bus.tx_sel} !== 2'b01) begin
      errors++;
      $display("FAIL frame_start_end: got %b expected 01", {bus.tx_start, bus.tx_sel});
    end
    bus.tx_busy = 1'b1;
    bus.buf_level = 12'd0;  // ignored outside IDLE
    ticks(50);  // t3..t52
    checks++;
    if (bus.tx_sel !== 1'b1) begin
      errors++;
      $display("FAIL frame_sel_send: got %b expected 1", bus.tx_sel);
    end
    bus.tx_busy = 1'b0;
    bus.buf_level = 12'd4;
    tick();  // t53: into IFG
    checks++;
    if (bus.tx_sel !== 1'b0) begin
      errors++;
      $display("FAIL frame_sel_ifg: got %b expected 0", bus.tx_sel);
    end
    for (int t = 54; t <= 61; t++) begin
      tick();
      if (bus.tx_start) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL frame_no_start_in_ifg: got %0d starts expected 0", early);
    end
    tick();  // t62: second start
    checks++;
    if ({bus.tx_start, bus.tx_sel} !== 2'b11) begin
      errors++;
      $display("FAIL frame_b2b_start: got %b expected 11", {bus.tx_start, bus.tx_sel});
    end
    checks++;
    if (bus.frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL frame_cnt_2: got %0d expected 2", bus.frame_cnt);
    end
  endtask

  // Scenario 3: fill reaches threshold on the tick the NLP timer expires.
  task automatic test_nlp_priority();
    do_reset();
    bus.enable = 1'b1;
    ticks(199);
    bus.buf_level = 12'd4;
    tick();  // t200
    checks++;
    if ({bus.nlp_pulse, bus.tx_start} !== 2'b10) begin
      errors++;
      $display("FAIL prio_nlp_first: got %b expected 10", {bus.nlp_pulse, bus.tx_start});
    end
    ticks(2);  // t202: NLP done
    checks++;
    if ({bus.nlp_pulse, bus.tx_start} !== 2'b00) begin
      errors++;
      $display("FAIL prio_nlp_end: got %b expected 00", {bus.nlp_pulse, bus.tx_start});
    end
    tick();  // t203
    checks++;
    if ({bus.tx_start, bus.frame_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL prio_start_after: got start=%b cnt=%0d expected start=1 cnt=1",
               bus.tx_start, bus.frame_cnt);
    end
  endtask

  // Scenario 4: enable drops mid-frame.
  task automatic test_enable_drop();
    int starts;
    starts = 0;
    do_reset();
    bus.enable = 1'b1;
    bus.buf_level = 12'd4;
    tick();  // t1 start
    bus.tx_busy = 1'b1;
    ticks(3);  // t4
    bus.enable = 1'b0;
    for (int t = 5; t <= 11; t++) begin
      tick();
      if (bus.tx_start) starts++;
    end
    checks++;
    if (bus.tx_sel !== 1'b1) begin
      errors++;
      $display("FAIL endrop_frame_continues: got %b expected 1", bus.tx_sel);
    end
    bus.tx_busy = 1'b0;
    tick();  // t12: into IFG
    checks++;
    if (bus.tx_sel !== 1'b0) begin
      errors++;
      $display("FAIL endrop_ifg: got %b expected 0", bus.tx_sel);
    end
    for (int t = 13; t <= 219; t++) begin
      tick();
      if (bus.tx_start) starts++;
    end
    checks++;
    if (bus.nlp_pulse !== 1'b0) begin
      errors++;
      $display("FAIL endrop_t219: got %b expected 0", bus.nlp_pulse);
    end
    tick();  // t220
    checks++;
    if (bus.nlp_pulse !== 1'b1) begin
      errors++;
      $display("FAIL endrop_nlp_resume: got %b expected 1", bus.nlp_pulse);
    end
    checks++;
    if ({starts, bus.frame_cnt} !== {32'd0, 16'd1}) begin
      errors++;
      $display("FAIL endrop_no_restart: got starts=%0d cnt=%0d expected 0/1",
               starts, bus.frame_cnt);
    end
  endtask

  // Scenario 5: serializer never goes busy.
  task automatic test_timeout();
    do_reset();
    bus.enable = 1'b1;
    bus.buf_level = 12'd4;
    ticks(65);  // t1 start, t2 SEND entry, t3..t65 = 63 SEND ticks
    checks++;
    if ({bus.tx_sel, bus.tx_err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_before: got %b expected 10", {bus.tx_sel, bus.tx_err});
    end
    tick();  // t66 = 64th SEND tick
`ifdef SCHED_TIMEOUT_EN
    checks++;
    if ({bus.tx_sel, bus.tx_err} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_fire: got %b expected 01", {bus.tx_sel, bus.tx_err});
    end
    ticks(8);  // t74: back to IDLE
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ifg_quiet: got %b expected 0", bus.tx_start);
    end
    tick();  // t75: restart from IDLE
    checks++;
    if ({bus.tx_start, bus.tx_err, bus.frame_cnt} !== {1'b1, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL timeout_idle_restart: got start=%b err=%b cnt=%0d expected 1/1/2",
               bus.tx_start, bus.tx_err, bus.frame_cnt);
    end
`else
    checks++;
    if ({bus.tx_sel, bus.tx_err} !== 2'b10) begin
      errors++;
      $display("FAIL nowd_at_64: got %b expected 10", {bus.tx_sel, bus.tx_err});
    end
    ticks(100);
    checks++;
    if ({bus.tx_sel, bus.tx_err, bus.tx_start, bus.frame_cnt} !== {3'b100, 16'd1}) begin
      errors++;
      $display("FAIL nowd_stays_send: got sel=%b err=%b start=%b cnt=%0d expected 1/0/0/1",
               bus.tx_sel, bus.tx_err, bus.tx_start, bus.frame_cnt);
    end
`endif
  endtask

  // Scenario 6: asynchronous reset in the middle of SEND.
  task automatic test_reset_mid_send();
    do_reset();
    bus.enable = 1'b1;
    bus.buf_level = 12'd4;
    tick();
    bus.tx_busy = 1'b1;
    ticks(8);
    checks++;
    if (bus.tx_sel !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_send: got %b expected 1", bus.tx_sel);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_start, bus.nlp_pulse, bus.tx_sel, bus.tx_err, bus.frame_cnt} !== {4'b0000, 16'd0}) begin
      errors++;
      $display("FAIL rstmid_async_clear: got start=%b nlp=%b sel=%b err=%b cnt=%0d expected all 0",
               bus.tx_start, bus.nlp_pulse, bus.tx_sel, bus.tx_err, bus.frame_cnt);
    end
    bus.tx_busy = 1'b0;
    bus.enable = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(199);
    checks++;
    if (bus.nlp_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_t199: got %b expected 0", bus.nlp_pulse);
    end
    tick();
    checks++;
    if (bus.nlp_pulse !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_first_nlp: got %b expected 1", bus.nlp_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_nlp_idle();
    test_frame();
    test_nlp_priority();
    test_enable_drop();
    test_timeout();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 1 ms");
    $fatal(1);
  end

endmodule
